// File: rtl/kmap_response_capture.sv
//==============================================================================
// kmap_response_capture: records the 16-entry truth table of a 4-input function
// and reports pass/fail against EXPECTED. Optional macro: KMAP_CONFLICT_DETECT_EN
// Revision: 1.0
//==============================================================================
`default_nettype none

module kmap_response_capture #(
   parameter logic [15:0] EXPECTED = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        in_valid_i,
   input  logic        a_i,
   input  logic        b_i,
   input  logic        c_i,
   input  logic        d_i,
   input  logic        f_i,
   output logic [15:0] table_out_o,
   output logic [15:0] seen_o,
   output logic [4:0]  count_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        conflict_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] table_q;
   logic [15:0] seen_q;
   logic [4:0]  count_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic        conflict_q;

   logic [3:0]  idx;
   logic [15:0] table_d;
   logic [15:0] seen_d;
   logic        hit_w;

   assign idx = {a_i, b_i, c_i, d_i};

   always_comb begin
      table_d      = table_q;
      table_d[idx] = f_i;
      seen_d       = seen_q;
      seen_d[idx]  = 1'b1;
   end

`ifdef KMAP_CONFLICT_DETECT_EN
   // A repeat sample disagreeing with the stored value means the function is unstable.
   assign hit_w = seen_q[idx] & (f_i ^ table_q[idx]);
`else
   assign hit_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         table_q    <= '0;
         seen_q     <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else if (start_i) begin
         state_q    <= S_COLLECT;
         table_q    <= '0;
         seen_q     <= '0;
         count_q    <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else if (state_q == S_COLLECT && in_valid_i) begin
         table_q    <= table_d;
         seen_q     <= seen_d;
         conflict_q <= conflict_q | hit_w;
         if (!seen_q[idx]) begin
            count_q <= count_q + 5'd1;
         end
         if (&seen_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (table_d == EXPECTED) && !(conflict_q | hit_w);
         end
      end
   end

   assign table_out_o = table_q;
   assign seen_o      = seen_q;
   assign count_o     = count_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign conflict_o  = conflict_q;

endmodule

`default_nettype wire
